// File: rtl/down_timer_if.sv
// Control/status bundle for the down_timer: load/control strobes in, count and expiry status out.
interface down_timer_if #(
    parameter int WIDTH = 32
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             stop;
    logic             auto_reload;
    logic             irq_clr;
    logic [WIDTH-1:0] count;
    logic             expired;
    logic             irq;
    logic             busy;

    modport master (
        output load, load_val, en, stop, auto_reload, irq_clr,
        input  count, expired, irq, busy
    );

    modport slave (
        input  load, load_val, en, stop, auto_reload, irq_clr,
        output count, expired, irq, busy
    );
endinterface

// File: rtl/down_timer.sv
// Loadable, pausable down-counting timer with one-cycle expiry pulse, sticky irq and optional auto-reload.
module down_timer #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    down_timer_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] W_ONE = WIDTH'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_reload_nxt;
    logic             r_expired;
    logic             w_expired_nxt;
    logic             r_irq;
    logic             w_irq_nxt;

    // Next-state logic: stop beats load, load beats decrement/expiry.
    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_reload_nxt  = r_reload;
        w_expired_nxt = 1'b0;
        if (bus.irq_clr) begin
            w_irq_nxt = 1'b0;
        end else begin
            w_irq_nxt = r_irq;
        end

        if (bus.stop) begin
            w_state_nxt = ST_IDLE;
        end else if (bus.load) begin
            w_count_nxt  = bus.load_val;
            w_reload_nxt = bus.load_val;
            if (bus.load_val != '0) begin
                w_state_nxt = ST_RUN;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_RUN, ST_PAUSE: begin
                    // A paused timer resumes counting on the same edge en returns.
                    if (!bus.en) begin
                        w_state_nxt = ST_PAUSE;
                    end else if (r_count == '0) begin
                        w_state_nxt = ST_IDLE;
                    end else if (r_count == W_ONE) begin
                        w_expired_nxt = 1'b1;
                        w_irq_nxt     = 1'b1;
                        if (bus.auto_reload) begin
                            w_count_nxt = r_reload;
                            w_state_nxt = ST_RUN;
                        end else begin
                            w_count_nxt = '0;
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_count_nxt = r_count - W_ONE;
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_reload  <= '0;
            r_expired <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_reload  <= w_reload_nxt;
            r_expired <= w_expired_nxt;
            r_irq     <= w_irq_nxt;
        end
    end

    assign bus.count   = r_count;
    assign bus.expired = r_expired;
    assign bus.irq     = r_irq;
    assign bus.busy    = (r_state != ST_IDLE);
endmodule

// File: tb/tb_down_timer.sv
// Directed self-checking bench for down_timer: one-shot, periodic, pause, collisions, zero load and reset.
module tb_down_timer;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   pulses;

    down_timer_if #(.WIDTH(32)) bus ();

    down_timer #(.WIDTH(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        pulses          = 0;
        rst             = 1'b0;
        bus.load        = 1'b0;
        bus.load_val    = 32'd0;
        bus.en          = 1'b0;
        bus.stop        = 1'b0;
        bus.auto_reload = 1'b0;
        bus.irq_clr     = 1'b0;

        // Reset state
        #12;
        chk("rst_count", bus.count, 32'd0);
        chk("rst_irq", {31'd0, bus.irq}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_expired", {31'd0, bus.expired}, 32'd0);
        rst = 1'b1;

        // One-shot: load 10
        bus.load = 1'b1; bus.load_val = 32'd10; bus.en = 1'b1; bus.auto_reload = 1'b0;
        tick();
        bus.load = 1'b0;
        chk("os_load_count", bus.count, 32'd10);
        chk("os_load_busy", {31'd0, bus.busy}, 32'd1);
        for (int i = 9; i >= 0; i--) begin
            tick();
            chk("os_count", bus.count, i);
            chk("os_expired", {31'd0, bus.expired}, (i == 0) ? 32'd1 : 32'd0);
            if (bus.expired) pulses++;
        end
        chk("os_irq", {31'd0, bus.irq}, 32'd1);
        chk("os_busy_end", {31'd0, bus.busy}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("os_hold_count", bus.count, 32'd0);
            if (bus.expired) pulses++;
        end
        chk("os_pulses", pulses, 32'd1);

        // Periodic: load 5, irq_clr pulse at step 21
        pulses = 0;
        bus.load = 1'b1; bus.load_val = 32'd5; bus.auto_reload = 1'b1;
        tick();
        bus.load = 1'b0;
        chk("per_load_count", bus.count, 32'd5);
        for (int k = 1; k <= 25; k++) begin
            bus.irq_clr = (k == 21);
            tick();
            chk("per_count", bus.count, ((k % 5) == 0) ? 32'd5 : 32'(5 - (k % 5)));
            chk("per_expired", {31'd0, bus.expired}, ((k % 5) == 0) ? 32'd1 : 32'd0);
            chk("per_irq", {31'd0, bus.irq}, (k >= 21 && k <= 24) ? 32'd0 : 32'd1);
            if (bus.expired) pulses++;
        end
        bus.irq_clr = 1'b0;
        chk("per_pulses", pulses, 32'd5);

        // irq_clr on the expiry edge: set wins
        bus.irq_clr = 1'b1;
        tick();
        bus.irq_clr = 1'b0;
        chk("clr_pre_irq", {31'd0, bus.irq}, 32'd0);
        tick();
        tick();
        tick();
        chk("clr_pre_count", bus.count, 32'd1);
        bus.irq_clr = 1'b1;
        tick();
        bus.irq_clr = 1'b0;
        chk("clr_edge_expired", {31'd0, bus.expired}, 32'd1);
        chk("clr_edge_irq", {31'd0, bus.irq}, 32'd1);
        chk("clr_edge_count", bus.count, 32'd5);

        // Load at count==1 suppresses expiry
        for (int i = 0; i < 4; i++) tick();
        chk("ldc_pre_count", bus.count, 32'd1);
        bus.load = 1'b1; bus.load_val = 32'd7;
        tick();
        bus.load = 1'b0; bus.auto_reload = 1'b0;
        chk("ldc_count", bus.count, 32'd7);
        chk("ldc_expired", {31'd0, bus.expired}, 32'd0);
        chk("ldc_busy", {31'd0, bus.busy}, 32'd1);

        // stop together with load: IDLE, count unchanged
        bus.stop = 1'b1; bus.load = 1'b1; bus.load_val = 32'd3;
        tick();
        bus.stop = 1'b0; bus.load = 1'b0;
        chk("stop_count", bus.count, 32'd7);
        chk("stop_busy", {31'd0, bus.busy}, 32'd0);
        chk("stop_expired", {31'd0, bus.expired}, 32'd0);
        tick();
        chk("idle_hold_count", bus.count, 32'd7);

        // Pause: load 8, 3 enabled, 4 paused, then enabled to expiry
        pulses = 0;
        bus.load = 1'b1; bus.load_val = 32'd8;
        tick();
        bus.load = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("pause_pre_count", bus.count, 32'd5);
        bus.en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("pause_count", bus.count, 32'd5);
            chk("pause_busy", {31'd0, bus.busy}, 32'd1);
            if (bus.expired) pulses++;
        end
        bus.en = 1'b1;
        for (int i = 4; i >= 0; i--) begin
            tick();
            chk("resume_count", bus.count, i);
            if (bus.expired) pulses++;
        end
        chk("pause_expired", {31'd0, bus.expired}, 32'd1);
        chk("pause_pulses", pulses, 32'd1);

        // en low on the count==1 cycle delays expiry
        bus.load = 1'b1; bus.load_val = 32'd2;
        tick();
        bus.load = 1'b0;
        tick();
        chk("enlow_pre_count", bus.count, 32'd1);
        bus.en = 1'b0;
        tick();
        chk("enlow_count", bus.count, 32'd1);
        chk("enlow_expired", {31'd0, bus.expired}, 32'd0);
        bus.en = 1'b1;
        tick();
        chk("enlow_late_expired", {31'd0, bus.expired}, 32'd1);
        chk("enlow_late_count", bus.count, 32'd0);

        // Load 0: IDLE, no expiry, irq unchanged
        bus.load = 1'b1; bus.load_val = 32'd0;
        tick();
        bus.load = 1'b0;
        chk("zero_busy", {31'd0, bus.busy}, 32'd0);
        chk("zero_count", bus.count, 32'd0);
        chk("zero_expired", {31'd0, bus.expired}, 32'd0);
        chk("zero_irq", {31'd0, bus.irq}, 32'd1);

        // Asynchronous reset mid-run
        bus.load = 1'b1; bus.load_val = 32'd100;
        tick();
        bus.load = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        chk("arst_pre_count", bus.count, 32'd70);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_count", bus.count, 32'd0);
        chk("arst_irq", {31'd0, bus.irq}, 32'd0);
        chk("arst_busy", {31'd0, bus.busy}, 32'd0);
        chk("arst_expired", {31'd0, bus.expired}, 32'd0);
        #4;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_count", bus.count, 32'd0);
            chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
- Loadable, pausable down-counting timer; the complementary block to the free-running up-counter.
- Software or a control FSM loads a cycle count. The block decrements it to expiry and raises a one-cycle expiry pulse plus a sticky interrupt.
- Optional auto-reload gives a periodic tick for the core's timer/interrupt path.

Parameters:
- WIDTH, 32, width of the count, load value and reload register.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- load  input  1  one-cycle strobe; capture load_val into count and reload register.
- load_val  input  WIDTH  initial/reload value, unsigned.
- en  input  1  count enable; low pauses the countdown.
- stop  input  1  abort countdown and return to IDLE.
- auto_reload  input  1  1 = periodic mode, 0 = one-shot.
- irq_clr  input  1  clears the sticky irq.
- count  output  WIDTH  current remaining count.
- expired  output  1  one-cycle pulse on expiry.
- irq  output  1  sticky expiry flag.
- busy  output  1  high in RUN or PAUSE.

Behaviour:
- Reset (rst low, async), all values:
  - count=0, reload register=0, expired=0, irq=0, busy=0, state=IDLE.
  - Applies immediately mid-operation; no expiry is generated by reset.
- Outputs are registered; expired is a registered pulse, high for exactly one cycle.
- States:
  - IDLE: count holds. en is ignored.
  - RUN: count decrements by 1 each cycle while en=1.
  - PAUSE: entered from RUN when en=0; count holds. Returns to RUN when en=1.
- Priority, each edge: stop > load > decrement/expiry.
  - stop=1: state<=IDLE, count holds its value, no expired pulse.
  - load=1 (stop=0), any state: count<=load_val and reload<=load_val.
    - If load_val!=0: state<=RUN.
    - If load_val==0: state<=IDLE with no expiry.
    - Load suppresses any expiry that would have occurred in the same cycle.
- Expiry: in RUN with en=1 and count==1, the next edge sets expired=1 and irq=1.
  - auto_reload=0: count<=0, state<=IDLE.
  - auto_reload=1: count<=reload, state stays RUN.
    - Period is exactly reload cycles.
    - Reload value 1 gives expired asserted every cycle.
- auto_reload is sampled at the expiry edge only; changing it mid-count affects only the next expiry.
- irq: set on expiry, cleared by irq_clr. When expiry and irq_clr occur on the same edge, set wins (irq=1).
- busy is combinational from state: 1 in RUN/PAUSE, 0 in IDLE.
- count never wraps below 0; decrementing from 0 cannot occur (IDLE at 0).
- en low on the count==1 cycle: no expiry; expiry occurs on the first enabled cycle afterwards.

Test Plan:
- One-shot:
  - Stimulus: reset, load 10, en=1, auto_reload=0.
  - Required: count steps 10,9,...,1,0. expired high exactly one cycle, on the edge count reaches 0, 10 cycles after load. irq=1, busy=0. count stays 0 for a further 20 cycles.
- Periodic:
  - Stimulus: load 5, auto_reload=1, en=1 for 20 cycles.
  - Required: count sequence 5,4,3,2,1,5,4,... expired pulses at cycles 5, 10, 15, 20 after load (4 pulses). irq stays 1. irq_clr pulse clears it until the next expiry.
- Pause:
  - Stimulus: load 8, en=1 for 3 cycles, en=0 for 4 cycles, en=1.
  - Required: count holds 5 while paused, busy=1 throughout. expired occurs 8 enabled cycles after load (12 total).
- Collisions:
  - Load at count==1 with load_val=7: count=7, no expired, state RUN.
  - irq_clr on the expiry edge: irq=1.
  - stop together with load: IDLE, count unchanged.
- Zero and reset:
  - load 0: busy=0, count=0, no expired, irq unchanged.
  - Load 100 run 30 cycles, then assert rst asynchronously mid-cycle. Required: count=0, irq=0, busy=0 immediately. After release, count stays 0 with en=1.
